dequantize_expand: RTL
======================

DEQUANTIZE_EXPAND -- requirements
Module: dequantize_expand

Interface
REQ-001 SHALL have parameter IN_W, default 8, signed input activation width (Q1.7 int8).
REQ-002 SHALL have parameter SCALE_W, default 16, signed per-channel scale width.
REQ-003 SHALL have parameter OUT_W, default 32, signed output accumulator-domain width.
REQ-004 SHALL have parameter NUM_CH, default 16, number of channels; CH_W = clog2(NUM_CH).
REQ-005 SHALL have port clk, input, 1, the single clock; rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port cfg_we, input, 1, table write strobe.
REQ-007 SHALL have port cfg_addr, input, CH_W, channel index for the table write.
REQ-008 SHALL have port cfg_scale, input, SCALE_W, signed scale to write.
REQ-009 SHALL have port cfg_offset, input, OUT_W, signed offset to write.
REQ-010 SHALL have ports s_valid in 1, s_ready out 1, s_data in IN_W signed, s_last in 1: input stream, s_last marks the final beat of a vector.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_data out OUT_W signed, m_last out 1: output stream.

Function
REQ-012 SHALL treat a beat as transferred when valid and ready are both high on a rising clk edge, on each stream.
REQ-013 SHALL compute m_data = sat_OUT_W(s_data * scale[ch] + offset[ch]), with a full-precision signed product (IN_W+SCALE_W bits) and an OUT_W+1-bit signed sum before saturation.
REQ-014 SHALL saturate the sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-015 SHALL use a two-stage pipeline: stage 1 registers product, offset and last; stage 2 registers the saturated sum into m_data/m_last.
REQ-016 SHALL present a beat on m_data two cycles after acceptance when m_ready is held high; sustained throughput one beat per cycle.
REQ-017 SHALL advance stage 2 when !m_valid || m_ready, stage 1 when stage 1 is empty or stage 2 advances; s_ready SHALL equal the stage-1 advance condition.
REQ-018 SHALL hold m_valid, m_data and m_last stable while m_valid && !m_ready.
REQ-019 SHALL lose no beat and duplicate no beat under any m_ready pattern.
REQ-020 SHALL keep a channel counter ch: 0 after reset; on each accepted beat, 0 if s_last, else 0 if ch==NUM_CH-1, else ch+1.
REQ-021 SHALL read scale[ch] and offset[ch] for a beat in its acceptance cycle.
REQ-022 SHALL write cfg_scale/cfg_offset to entry cfg_addr on a cfg_we edge; the new value applies to beats accepted in later cycles.
REQ-023 SHALL give a beat accepted in the same cycle as a write to its channel the old table value.
REQ-024 SHALL pass s_last to m_last aligned with its beat.

Reset
REQ-025 SHALL on rst clear m_valid, m_last, m_data, stage-1 valid and ch to 0, and drop in-flight beats.
REQ-026 SHALL on rst set every scale entry to 1 and every offset entry to 0 (identity).
REQ-027 SHALL hold s_ready low during the reset cycle and drive it per REQ-017 from the first cycle after.

Structure
REQ-028 SHALL place default widths, NUM_CH and saturation bounds in the shared quantization package used by the requantize stage.
REQ-029 SHALL keep the scale/offset table inside the module; a separate sub-module SHALL NOT be used.

Verification
REQ-030 Reset tables, m_ready=1, s_data=-128,127,0 -> m_data=-128,127,0 two cycles after each accept.
REQ-031 cfg ch0 scale=16384 offset=100, s_data=3 on ch0 -> m_data=49252.
REQ-032 cfg scale=32767 offset=2^31-1000, s_data=127 -> m_data=2147483647; scale=-32768 offset=-2^31, s_data=127 -> m_data=-2147483648.
REQ-033 NUM_CH=16, 20 beats no s_last -> beats 0-15 use ch0-15, beats 16-19 use ch0-3; s_last on beat 5 -> beat 6 uses ch0 and m_last follows beat 5.
REQ-034 Random m_ready, 1000 random beats -> output sequence equals reference model, m_data stable while stalled, s_ready low only with both stages full and m_ready low.
REQ-035 cfg write to ch2 in the same cycle as a ch2 accept -> that beat uses the old value, the next ch2 beat the new one; rst mid-stream -> m_valid=0 the next cycle and tables back to identity.

Source files
------------

// File: rtl/dequantize_expand_pkg.sv
// Shared quantization constants: default datapath widths, channel count and
// the saturation bounds of the default accumulator-domain width.
package dequantize_expand_pkg;

  localparam int unsigned DQ_IN_W    = 8;
  localparam int unsigned DQ_SCALE_W = 16;
  localparam int unsigned DQ_OUT_W   = 32;
  localparam int unsigned DQ_NUM_CH  = 16;

  localparam logic signed [DQ_OUT_W-1:0] DQ_SAT_MAX = {1'b0, {(DQ_OUT_W-1){1'b1}}};
  localparam logic signed [DQ_OUT_W-1:0] DQ_SAT_MIN = {1'b1, {(DQ_OUT_W-1){1'b0}}};

endpackage

// File: rtl/dequantize_expand.sv
// Per-channel dequantization: m_data = sat(s_data * scale[ch] + offset[ch]),
// two-stage valid/ready pipeline with an internal scale/offset table.
module dequantize_expand
  import dequantize_expand_pkg::*;
#(
  parameter int unsigned IN_W    = DQ_IN_W,
  parameter int unsigned SCALE_W = DQ_SCALE_W,
  parameter int unsigned OUT_W   = DQ_OUT_W,
  parameter int unsigned NUM_CH  = DQ_NUM_CH,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_addr,
  input  logic signed [SCALE_W-1:0] cfg_scale,
  input  logic signed [OUT_W-1:0]   cfg_offset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [IN_W-1:0]    s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [OUT_W-1:0]   m_data,
  output logic                      m_last
);

  localparam int unsigned PROD_W = IN_W + SCALE_W;
  localparam int unsigned SUM_W  = OUT_W + 1;
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [SCALE_W-1:0] r_scale [NUM_CH];
  logic signed [OUT_W-1:0]   r_offset [NUM_CH];
  logic [CH_W-1:0]           r_ch;

  logic                      r_s1_valid;
  logic signed [PROD_W-1:0]  r_s1_prod;
  logic signed [OUT_W-1:0]   r_s1_off;
  logic                      r_s1_last;

  logic                      r_m_valid;
  logic signed [OUT_W-1:0]   r_m_data;
  logic                      r_m_last;

  logic                      w_s2_adv;
  logic                      w_s1_adv;
  logic                      w_accept;
  logic signed [SCALE_W-1:0] w_scale;
  logic signed [OUT_W-1:0]   w_offset;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [OUT_W-1:0]   w_sat;

  assign w_s2_adv = !r_m_valid || m_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign s_ready  = !rst && w_s1_adv;
  assign w_accept = s_valid && s_ready;

  // Table is read combinationally, so a same-edge write is seen only by later beats.
  assign w_scale  = r_scale[r_ch];
  assign w_offset = r_offset[r_ch];
  assign w_prod   = PROD_W'(s_data) * PROD_W'(w_scale);

  assign w_sum = SUM_W'(r_s1_prod) + SUM_W'(r_s1_off);
  // Overflow of the OUT_W range shows up as the top two sum bits disagreeing.
  assign w_sat = (w_sum[OUT_W] != w_sum[OUT_W-1]) ?
                 (w_sum[OUT_W] ? SAT_MIN : SAT_MAX) : w_sum[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_scale[i]  <= SCALE_W'(1);
        r_offset[i] <= '0;
      end
    end else if (cfg_we) begin
      r_scale[cfg_addr]  <= cfg_scale;
      r_offset[cfg_addr] <= cfg_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch <= '0;
    end else if (w_accept) begin
      r_ch <= (s_last || (r_ch == CH_W'(NUM_CH - 1))) ? '0 : r_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_off   <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_prod <= w_prod;
        r_s1_off  <= w_offset;
        r_s1_last <= s_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_s2_adv) begin
      r_m_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_m_data <= w_sat;
        r_m_last <= r_s1_last;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;

endmodule
